// File: rtl/kernel_cache_read_requester.sv
// AXI4 read initiator for the kernel cache slave port: issues one AR burst per
// request, tracks bursts in flight, and returns R beats through a one-entry register.
module kernel_cache_read_requester #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  input  logic [ID_W-1:0]   req_id,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [ID_W-1:0]   m_arid,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ID_W-1:0]   resp_id,
  output logic              resp_last,
  output logic              resp_err,
  output logic [CNT_W-1:0]  outstanding,
  output logic              error_sticky,
  output logic              idle
);
  typedef enum logic {AR_IDLE, AR_ISSUE} ar_st_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_st_e              st_q, st_d;
  logic [ADDR_W-1:0]   araddr_q;
  logic [7:0]          arlen_q;
  logic [ID_W-1:0]     arid_q;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic                err_q, err_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ID_W-1:0]     rid_q;
  logic                rlast_q, rerr_q;
  logic                req_hs, ar_hs, r_hs, r_done;

  always_ff @(posedge ap_clk or posedge areset)
    if (areset) st_q <= AR_IDLE;
    else        st_q <= st_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      AR_IDLE:  if (req_valid && req_ready) st_d = AR_ISSUE;
      AR_ISSUE: if (m_arready)              st_d = AR_IDLE;
      default:                              st_d = AR_IDLE;
    endcase
  end

  // Nothing is pending while idle, so the gate reduces to the in-flight count.
  always_comb begin
    req_ready = 1'b0;
    m_arvalid = 1'b0;
    case (st_q)
      AR_IDLE:  req_ready = ~areset & (outst_q < MAX_CNT);
      AR_ISSUE: m_arvalid = 1'b1;
      default: ;
    endcase
  end

  assign req_hs = req_valid & req_ready;
  assign ar_hs  = m_arvalid & m_arready;
  assign r_hs   = m_rvalid & m_rready;
  assign r_done = r_hs & m_rlast;

  always_ff @(posedge ap_clk or posedge areset)
    if (areset) begin
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
    end else if (req_hs) begin
      araddr_q <= {req_addr[ADDR_W-1:6], 6'b0};
      arlen_q  <= req_len;
      arid_q   <= req_id;
    end

  always_comb begin
    outst_d = outst_q;
    case ({ar_hs, r_done})
      2'b10:   if (outst_q != MAX_CNT) outst_d = outst_q + 1'b1;
      2'b01:   if (outst_q != '0)      outst_d = outst_q - 1'b1;
      default: ;
    endcase
    err_d = err_q | (r_hs & (m_rresp != 2'b00)) | (m_rvalid & (outst_q == '0))
          | (req_hs & (req_addr[5:0] != 6'b0));
  end

  always_ff @(posedge ap_clk or posedge areset)
    if (areset) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end

  always_ff @(posedge ap_clk or posedge areset)
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rlast_q  <= 1'b0;
      rerr_q   <= 1'b0;
    end else if (r_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= m_rdata;
      rid_q    <= m_rid;
      rlast_q  <= m_rlast;
      rerr_q   <= (m_rresp != 2'b00);
    end else if (resp_ready) begin
      rvalid_q <= 1'b0;
    end

  assign m_rready     = ~areset & (~rvalid_q | resp_ready);
  assign m_araddr     = araddr_q;
  assign m_arlen      = arlen_q;
  assign m_arid       = arid_q;
  assign m_arsize     = 3'b110;
  assign m_arburst    = 2'b01;
  assign resp_valid   = rvalid_q;
  assign resp_data    = rdata_q;
  assign resp_id      = rid_q;
  assign resp_last    = rlast_q;
  assign resp_err     = rerr_q;
  assign outstanding  = outst_q;
  assign error_sticky = err_q;
  assign idle         = (st_q == AR_IDLE) && (outst_q == '0) && !rvalid_q;
endmodule
